// File: rtl/ethernet_header_parser.sv
// RX Ethernet header parser: strips the 14-byte header, latches its fields,
// filters frames on destination MAC and forwards payload with backpressure.
module ethernet_header_parser #(
  parameter bit PROMISCUOUS = 1'b0,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [47:0]          local_mac,
  input  logic [7:0]           s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 hdr_valid,
  output logic [47:0]          hdr_mac_destination,
  output logic [47:0]          hdr_mac_source,
  output logic [15:0]          hdr_eth_type_length,
  output logic                 rx_runt,
  output logic [CNT_WIDTH-1:0] drop_count,
  output logic [CNT_WIDTH-1:0] runt_count
);

  typedef enum logic [1:0] {HEADER, PAYLOAD, DROP} state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_e               state_q;
  logic [3:0]           idx_q;
  logic [47:0]          dst_q, src_q;
  logic [15:0]          type_q;
  logic                 match_q;
  logic [47:0]          hdr_dst_q, hdr_src_q;
  logic [15:0]          hdr_type_q;
  logic                 hdr_valid_q, rx_runt_q;
  logic [CNT_WIDTH-1:0] drop_cnt_q, runt_cnt_q;

  logic        in_fire;
  logic        in_payload;
  logic [47:0] dst_d, src_d;
  logic [15:0] type_d;
  logic        mac_match;

  assign in_payload = (state_q == PAYLOAD);
  assign in_fire    = s_axis_tvalid & s_axis_tready;

  assign s_axis_tready = in_payload ? m_axis_tready : 1'b1;
  assign m_axis_tvalid = in_payload & s_axis_tvalid;
  assign m_axis_tlast  = in_payload & s_axis_tlast;
  assign m_axis_tdata  = in_payload ? s_axis_tdata : 8'h00;

  // Fields are shifted in MSB-first, so each incoming byte lands in the low byte.
  assign dst_d  = {dst_q[39:0], s_axis_tdata};
  assign src_d  = {src_q[39:0], s_axis_tdata};
  assign type_d = {type_q[7:0], s_axis_tdata};

  // Evaluated while header byte 5 is accepted, when dst_d holds the full address.
  assign mac_match = PROMISCUOUS || (dst_d == local_mac) || (dst_d == 48'hFFFF_FFFF_FFFF);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HEADER;
      idx_q       <= 4'd0;
      dst_q       <= '0;
      src_q       <= '0;
      type_q      <= '0;
      match_q     <= 1'b0;
      hdr_dst_q   <= '0;
      hdr_src_q   <= '0;
      hdr_type_q  <= '0;
      hdr_valid_q <= 1'b0;
      rx_runt_q   <= 1'b0;
      drop_cnt_q  <= '0;
      runt_cnt_q  <= '0;
    end else begin
      hdr_valid_q <= 1'b0;
      rx_runt_q   <= 1'b0;
      if (in_fire) begin
        case (state_q)
          HEADER: begin
            if (idx_q <= 4'd5) begin
              dst_q <= dst_d;
            end else if (idx_q <= 4'd11) begin
              src_q <= src_d;
            end else begin
              type_q <= type_d;
            end
            if (idx_q == 4'd5) begin
              match_q <= mac_match;
            end
            // A frame ending anywhere in the header, including byte 13, is a runt.
            if (s_axis_tlast) begin
              rx_runt_q <= 1'b1;
              idx_q     <= 4'd0;
              if (~&runt_cnt_q) begin
                runt_cnt_q <= runt_cnt_q + CNT_ONE;
              end
            end else if (idx_q == 4'd13) begin
              idx_q <= 4'd0;
              if (match_q) begin
                state_q     <= PAYLOAD;
                hdr_dst_q   <= dst_q;
                hdr_src_q   <= src_q;
                hdr_type_q  <= type_d;
                hdr_valid_q <= 1'b1;
              end else begin
                state_q <= DROP;
                if (~&drop_cnt_q) begin
                  drop_cnt_q <= drop_cnt_q + CNT_ONE;
                end
              end
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end
          PAYLOAD, DROP: begin
            if (s_axis_tlast) begin
              state_q <= HEADER;
            end
          end
          default: state_q <= HEADER;
        endcase
      end
    end
  end

  assign hdr_valid           = hdr_valid_q;
  assign rx_runt             = rx_runt_q;
  assign hdr_mac_destination = hdr_dst_q;
  assign hdr_mac_source      = hdr_src_q;
  assign hdr_eth_type_length = hdr_type_q;
  assign drop_count          = drop_cnt_q;
  assign runt_count          = runt_cnt_q;

endmodule

// File: tb/tb_ethernet_header_parser.sv
// Randomised bench for ethernet_header_parser: three instances (default, promiscuous,
// 2-bit counters) checked against a per-frame reference model.
module tb_ethernet_header_parser;

  logic        clk;
  logic        reset;
  logic [47:0] localMac;
  logic [7:0]  sData;
  logic        sValid, sLast, mReady;
  int          sel;
  bit          randReady;

  logic        sValidD [3];
  logic        sReadyD [3];
  logic [7:0]  mDataD [3];
  logic        mValidD [3], mLastD [3], hdrValidD [3], rxRuntD [3];
  logic [47:0] hdrDstD [3], hdrSrcD [3];
  logic [15:0] hdrTypeD [3];
  logic [15:0] dropC0, runtC0, dropC1, runtC1;
  logic [1:0]  dropC2, runtC2;

  logic        curReady, curMValid, curMLast, curHdrValid, curRxRunt;
  logic [7:0]  curMData;
  logic [47:0] curDst, curSrc;
  logic [15:0] curType, curDrop, curRunt;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  txFrame [$];
  logic [7:0]  pendBytes [$];
  int          pendLen [$];
  logic [7:0]  curB [0:255];
  int          curLen, pos;
  bit          curRunt_m, curAccept, expHdr, expRunt;
  int          dropsM [3], runtsM [3];
  logic [47:0] hdrDstM [3], hdrSrcM [3];
  logic [15:0] hdrTypeM [3];

  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

  assign sValidD[0] = sValid && (sel == 0);
  assign sValidD[1] = sValid && (sel == 1);
  assign sValidD[2] = sValid && (sel == 2);

  ethernet_header_parser #(.PROMISCUOUS(1'b0), .CNT_WIDTH(16)) dut0 (
    .clk(clk), .reset(reset), .local_mac(localMac),
    .s_axis_tdata(sData), .s_axis_tvalid(sValidD[0]), .s_axis_tready(sReadyD[0]), .s_axis_tlast(sLast),
    .m_axis_tdata(mDataD[0]), .m_axis_tvalid(mValidD[0]), .m_axis_tready(mReady), .m_axis_tlast(mLastD[0]),
    .hdr_valid(hdrValidD[0]), .hdr_mac_destination(hdrDstD[0]), .hdr_mac_source(hdrSrcD[0]),
    .hdr_eth_type_length(hdrTypeD[0]), .rx_runt(rxRuntD[0]), .drop_count(dropC0), .runt_count(runtC0));

  ethernet_header_parser #(.PROMISCUOUS(1'b1), .CNT_WIDTH(16)) dut1 (
    .clk(clk), .reset(reset), .local_mac(localMac),
    .s_axis_tdata(sData), .s_axis_tvalid(sValidD[1]), .s_axis_tready(sReadyD[1]), .s_axis_tlast(sLast),
    .m_axis_tdata(mDataD[1]), .m_axis_tvalid(mValidD[1]), .m_axis_tready(mReady), .m_axis_tlast(mLastD[1]),
    .hdr_valid(hdrValidD[1]), .hdr_mac_destination(hdrDstD[1]), .hdr_mac_source(hdrSrcD[1]),
    .hdr_eth_type_length(hdrTypeD[1]), .rx_runt(rxRuntD[1]), .drop_count(dropC1), .runt_count(runtC1));

  ethernet_header_parser #(.PROMISCUOUS(1'b0), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .local_mac(localMac),
    .s_axis_tdata(sData), .s_axis_tvalid(sValidD[2]), .s_axis_tready(sReadyD[2]), .s_axis_tlast(sLast),
    .m_axis_tdata(mDataD[2]), .m_axis_tvalid(mValidD[2]), .m_axis_tready(mReady), .m_axis_tlast(mLastD[2]),
    .hdr_valid(hdrValidD[2]), .hdr_mac_destination(hdrDstD[2]), .hdr_mac_source(hdrSrcD[2]),
    .hdr_eth_type_length(hdrTypeD[2]), .rx_runt(rxRuntD[2]), .drop_count(dropC2), .runt_count(runtC2));

  always_comb begin
    curReady    = sReadyD[0];
    curMValid   = mValidD[0];
    curMLast    = mLastD[0];
    curMData    = mDataD[0];
    curHdrValid = hdrValidD[0];
    curRxRunt   = rxRuntD[0];
    curDst      = hdrDstD[0];
    curSrc      = hdrSrcD[0];
    curType     = hdrTypeD[0];
    curDrop     = dropC0;
    curRunt     = runtC0;
    if (sel == 1) begin
      curReady = sReadyD[1]; curMValid = mValidD[1]; curMLast = mLastD[1]; curMData = mDataD[1];
      curHdrValid = hdrValidD[1]; curRxRunt = rxRuntD[1];
      curDst = hdrDstD[1]; curSrc = hdrSrcD[1]; curType = hdrTypeD[1];
      curDrop = dropC1; curRunt = runtC1;
    end else if (sel == 2) begin
      curReady = sReadyD[2]; curMValid = mValidD[2]; curMLast = mLastD[2]; curMData = mDataD[2];
      curHdrValid = hdrValidD[2]; curRxRunt = rxRuntD[2];
      curDst = hdrDstD[2]; curSrc = hdrSrcD[2]; curType = hdrTypeD[2];
      curDrop = {14'd0, dropC2}; curRunt = {14'd0, runtC2};
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    mReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      mReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int satInc(input int cur, input int k);
    int maxv;
    maxv = (k == 2) ? 3 : 65535;
    return (cur < maxv) ? cur + 1 : cur;
  endfunction

  task automatic modelReset();
    pendBytes.delete();
    pendLen.delete();
    pos = 0;
    expHdr = 0;
    expRunt = 0;
    for (int k = 0; k < 3; k++) begin
      dropsM[k] = 0; runtsM[k] = 0;
      hdrDstM[k] = '0; hdrSrcM[k] = '0; hdrTypeM[k] = '0;
    end
  endtask

  // Reference model: each frame is classified once, when its first byte is accepted.
  task automatic loadFrame();
    logic [47:0] d;
    curLen = pendLen.pop_front();
    for (int i = 0; i < curLen; i++) curB[i] = pendBytes.pop_front();
    d = '0;
    for (int i = 0; i < 6 && i < curLen; i++) d = (d << 8) | 48'(curB[i]);
    curRunt_m = (curLen <= 14);
    curAccept = !curRunt_m && ((sel == 1) || (d == localMac) || (d == BCAST));
  endtask

  initial begin
    bit inPay;
    logic [47:0] d, s;
    modelReset();
    forever begin
      @(negedge clk);
      if (reset) begin
        modelReset();
      end else begin
        inPay = (pos >= 14) && curAccept;
        checkOutput("hdrValid", curHdrValid, expHdr);
        checkOutput("rxRunt", curRxRunt, expRunt);
        checkOutput("sReady", curReady, inPay ? mReady : 1'b1);
        checkOutput("mValid", curMValid, inPay && sValid);
        checkOutput("hdrDst", curDst, hdrDstM[sel]);
        checkOutput("hdrSrc", curSrc, hdrSrcM[sel]);
        checkOutput("hdrType", curType, hdrTypeM[sel]);
        checkOutput("dropCount", curDrop, 64'(dropsM[sel]));
        checkOutput("runtCount", curRunt, 64'(runtsM[sel]));
        if (inPay && sValid && mReady) begin
          checkOutput("payloadData", curMData, curB[pos]);
          checkOutput("payloadLast", curMLast, pos == curLen - 1);
        end
        expHdr = 0;
        expRunt = 0;
        if (sValid && curReady) begin
          if (pos == 0) begin
            if (pendLen.size() == 0) begin
              checkOutput("unexpectedBeat", 1, 0);
              continue;
            end
            loadFrame();
          end
          if (curRunt_m && pos == curLen - 1) begin
            expRunt = 1;
            runtsM[sel] = satInc(runtsM[sel], sel);
            pos = 0;
          end else if (pos == 13) begin
            if (curAccept) begin
              d = '0; s = '0;
              for (int i = 0; i < 6; i++) d = (d << 8) | 48'(curB[i]);
              for (int i = 6; i < 12; i++) s = (s << 8) | 48'(curB[i]);
              expHdr = 1;
              hdrDstM[sel] = d;
              hdrSrcM[sel] = s;
              hdrTypeM[sel] = {curB[12], curB[13]};
            end else begin
              dropsM[sel] = satInc(dropsM[sel], sel);
            end
            pos++;
          end else if (pos == curLen - 1) begin
            pos = 0;
          end else begin
            pos++;
          end
        end
      end
    end
  end

  task automatic buildFrame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] typ, input int len);
    logic [7:0] hdr [14];
    for (int i = 0; i < 6; i++) hdr[i] = dst[47 - 8*i -: 8];
    for (int i = 0; i < 6; i++) hdr[6 + i] = src[47 - 8*i -: 8];
    hdr[12] = typ[15:8];
    hdr[13] = typ[7:0];
    txFrame.delete();
    for (int i = 0; i < len; i++) txFrame.push_back(i < 14 ? hdr[i] : 8'($urandom));
  endtask

  // Drives txFrame into the selected instance; abortAt >= 0 pulses reset before that byte.
  task automatic applyStimulus(input bit gaps, input int abortAt);
    int i, guard;
    i = 0;
    guard = 0;
    pendLen.push_back(txFrame.size());
    foreach (txFrame[j]) pendBytes.push_back(txFrame[j]);
    while (i < txFrame.size()) begin
      if (i == abortAt) begin
        sValid = 1'b0; sLast = 1'b0; reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        return;
      end
      sValid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      sData  = txFrame[i];
      sLast  = (i == txFrame.size() - 1);
      @(negedge clk);
      if (sValid && curReady) i++;
      @(posedge clk);
      #1;
      guard++;
      if (guard > 3000) begin
        checkOutput("driveTimeout", 1, 0);
        break;
      end
    end
    sValid = 1'b0;
    sLast  = 1'b0;
    sData  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [47:0] dst;
    int len;
    reset = 1'b1; sValid = 1'b0; sLast = 1'b0; sData = 8'h00; sel = 0; randReady = 0;
    localMac = 48'h02_00_00_00_00_01;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    buildFrame(48'h02_00_00_00_00_01, 48'hAA_BB_CC_DD_EE_FF, 16'h0800, 14 + 46);
    applyStimulus(0, -1);
    idle(2);

    buildFrame(BCAST, 48'h11_22_33_44_55_66, 16'h86DD, 18);
    applyStimulus(0, -1);
    buildFrame(48'h02_00_00_00_00_02, 48'h11_22_33_44_55_66, 16'h0806, 18);
    applyStimulus(0, -1);
    idle(1);
    checkOutput("dropAfterFilter", curDrop, 1);
    sel = 1;
    applyStimulus(0, -1);
    idle(1);
    sel = 0;

    buildFrame(48'h02_00_00_00_00_01, 48'h12_34_56_78_9A_BC, 16'h0800, 10);
    applyStimulus(0, -1);
    idle(1);
    checkOutput("runtAfterShort", curRunt, 1);
    buildFrame(48'h02_00_00_00_00_01, 48'h12_34_56_78_9A_BC, 16'h0800, 14);
    applyStimulus(0, -1);
    buildFrame(48'h02_00_00_00_00_01, 48'hCA_FE_00_00_00_01, 16'h0042, 15);
    applyStimulus(0, -1);
    idle(2);

    randReady = 1;
    for (int f = 0; f < 100; f++) begin
      case ($urandom_range(0, 3))
        0, 3: dst = localMac;
        1: dst = BCAST;
        default: begin
          dst = {16'($urandom), 32'($urandom)};
          if (dst == localMac || dst == BCAST) dst = 48'h06_00_00_00_00_07;
        end
      endcase
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 14) : $urandom_range(15, 40);
      buildFrame(dst, {16'($urandom), 32'($urandom)}, 16'($urandom), len);
      applyStimulus(1, -1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    randReady = 0;
    idle(2);

    sel = 2;
    for (int f = 0; f < 5; f++) begin
      buildFrame(48'h02_00_00_00_00_09, 48'h0A_0B_0C_0D_0E_0F, 16'h0800, 20);
      applyStimulus(0, -1);
    end
    for (int f = 0; f < 4; f++) begin
      buildFrame(48'h02_00_00_00_00_01, 48'h0A_0B_0C_0D_0E_0F, 16'h0800, 5);
      applyStimulus(0, -1);
    end
    idle(1);
    checkOutput("dropSaturated", curDrop, 3);
    checkOutput("runtSaturated", curRunt, 3);
    sel = 0;

    buildFrame(48'h02_00_00_00_00_01, 48'hAA_BB_CC_DD_EE_FF, 16'h0800, 14 + 46);
    applyStimulus(0, 34);
    idle(1);
    checkOutput("resetDrop", curDrop, 0);
    buildFrame(48'h02_00_00_00_00_01, 48'h01_02_03_04_05_06, 16'h0801, 24);
    applyStimulus(0, -1);
    idle(3);

    checkOutput("framesDrained", 64'(pendLen.size()), 0);
    checkOutput("modelIdle", 64'(pos), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
